// File: rtl/fft_frame_sequencer.sv
// Serial-to-parallel front end for an 8-point FFT core: fill, load, start, wait, capture, drain.
// Build with FFT_SEQ_SCALE_EN defined to store each captured result component scaled by 1/8 with rounding.
module fft_frame_sequencer #(
  parameter int DATA_W      = 16,
  parameter int FFT_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_real,
  input  logic [DATA_W-1:0]   s_imag,
  input  logic                s_last,
  output logic                fft_write,
  output logic                fft_start,
  output logic [8*DATA_W-1:0] fft_in_real,
  output logic [8*DATA_W-1:0] fft_in_imag,
  input  logic [8*DATA_W-1:0] fft_out_real,
  input  logic [8*DATA_W-1:0] fft_out_imag,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_real,
  output logic [DATA_W-1:0]   m_imag,
  output logic [2:0]          m_index,
  output logic                m_last,
  output logic                busy,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frame_count
);

  typedef enum logic [2:0] {FILL, LOAD, START, WAIT, DRAIN} state_t;

  localparam logic [7:0] LAT_LAST = 8'(FFT_LATENCY - 1);

  state_t            state;
  logic [2:0]        wr_idx;
  logic [2:0]        rd_idx;
  logic [7:0]        lat_cnt;
  logic [DATA_W-1:0] in_re  [8];
  logic [DATA_W-1:0] in_im  [8];
  logic [DATA_W-1:0] res_re [8];
  logic [DATA_W-1:0] res_im [8];

  function automatic logic [DATA_W-1:0] capture_val(input logic [DATA_W-1:0] x);
`ifdef FFT_SEQ_SCALE_EN
    logic signed [DATA_W:0] e;
    e = $signed({x[DATA_W-1], x}) + $signed((DATA_W+1)'(4));
    e = e >>> 3;
    return e[DATA_W-1:0];
`else
    return x;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_idx      <= 3'd0;
      rd_idx      <= 3'd0;
      lat_cnt     <= 8'd0;
      s_ready     <= 1'b1;
      fft_write   <= 1'b0;
      fft_start   <= 1'b0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < 8; i++) begin
        in_re[i]  <= '0;
        in_im[i]  <= '0;
        res_re[i] <= '0;
        res_im[i] <= '0;
      end
    end else begin
      fft_write <= 1'b0;
      fft_start <= 1'b0;
      case (state)
        FILL: begin
          if (s_valid && s_ready) begin
            // An early s_last drops the partial frame; the old slot contents are simply overwritten later.
            if (s_last && wr_idx != 3'd7) begin
              frame_err <= 1'b1;
              wr_idx    <= 3'd0;
            end else begin
              in_re[wr_idx] <= s_real;
              in_im[wr_idx] <= s_imag;
              if (wr_idx == 3'd7) begin
                wr_idx    <= 3'd0;
                state     <= LOAD;
                s_ready   <= 1'b0;
                fft_write <= 1'b1;
                busy      <= 1'b1;
              end else begin
                wr_idx <= wr_idx + 3'd1;
              end
            end
          end
        end
        LOAD: begin
          state     <= START;
          fft_start <= 1'b1;
        end
        START: begin
          state   <= WAIT;
          lat_cnt <= 8'd0;
        end
        WAIT: begin
          // First WAIT cycle is START+1, so count LAT-1 lands on cycle START+FFT_LATENCY.
          if (lat_cnt == LAT_LAST) begin
            for (int k = 0; k < 8; k++) begin
              res_re[k] <= capture_val(fft_out_real[k*DATA_W +: DATA_W]);
              res_im[k] <= capture_val(fft_out_imag[k*DATA_W +: DATA_W]);
            end
            state   <= DRAIN;
            m_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (rd_idx == 3'd7) begin
              rd_idx      <= 3'd0;
              frame_count <= frame_count + CNT_W'(1);
              state       <= FILL;
              m_valid     <= 1'b0;
              s_ready     <= 1'b1;
              busy        <= 1'b0;
            end else begin
              rd_idx <= rd_idx + 3'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign fft_in_real[k*DATA_W +: DATA_W] = in_re[k];
    assign fft_in_imag[k*DATA_W +: DATA_W] = in_im[k];
  end

  // rd_idx only leaves 0 inside DRAIN, so the read port is quiet elsewhere.
  assign m_real  = res_re[rd_idx];
  assign m_imag  = res_im[rd_idx];
  assign m_index = rd_idx;
  assign m_last  = (rd_idx == 3'd7);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a behavioural 8-point DFT core of fixed latency.
module tb_fft_frame_sequencer;

  localparam int DW  = 16;
  localparam int LAT = 4;
  localparam int CW  = 2;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_real, s_imag;
  logic          fft_write, fft_start;
  logic [8*DW-1:0] fft_in_real, fft_in_imag, fft_out_real, fft_out_imag;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_real, m_imag;
  logic [2:0]    m_index;
  logic          busy, frame_err;
  logic [CW-1:0] frame_count;

  fft_frame_sequencer #(.DATA_W(DW), .FFT_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .fft_write(fft_write), .fft_start(fft_start),
    .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last),
    .busy(busy), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] dft_part(input logic [127:0] xr, input logic [127:0] xi, input bit want_im);
    logic [127:0] y;
    real ar, ai, a, b, ang, v;
    int t, iv;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 8; n++) begin
        t = $signed(xr[n*16 +: 16]);
        a = $itor(t);
        t = $signed(xi[n*16 +: 16]);
        b = $itor(t);
        ang = 2.0 * PI * $itor(k * n) / 8.0;
        ar = ar + a * $cos(ang) + b * $sin(ang);
        ai = ai + b * $cos(ang) - a * $sin(ang);
      end
      v = want_im ? ai : ar;
      iv = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
      y[k*16 +: 16] = iv[15:0];
    end
    return y;
  endfunction

  function automatic logic [127:0] scale_vec(input logic [127:0] v);
`ifdef FFT_SEQ_SCALE_EN
    logic [127:0] y;
    int t;
    for (int k = 0; k < 8; k++) begin
      t = $signed(v[k*16 +: 16]);
      t = (t + 4) >>> 3;
      y[k*16 +: 16] = t[15:0];
    end
    return y;
`else
    return v;
`endif
  endfunction

  // Core model: latches inputs on fft_write, result is valid only on cycle START+LAT.
  logic [127:0] core_in_re = '0, core_in_im = '0, core_re = '0, core_im = '0;
  int core_cnt = 0;
  always @(posedge clk) begin
    if (fft_write) begin
      core_in_re <= fft_in_real;
      core_in_im <= fft_in_imag;
    end
    if (fft_start) begin
      core_re  <= dft_part(core_in_re, core_in_im, 1'b0);
      core_im  <= dft_part(core_in_re, core_in_im, 1'b1);
      core_cnt <= 1;
    end else if (core_cnt != 0 && core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
  end
  assign fft_out_real = (core_cnt == LAT) ? core_re : {8{16'hDEAD}};
  assign fft_out_imag = (core_cnt == LAT) ? core_im : {8{16'hBEEF}};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_write = 0, n_start = 0, write_cyc = 0, start_cyc = 0, mv_cyc = 0;
  bit mv_seen = 1'b0;
  always @(negedge clk) begin
    if (fft_write) begin n_write++; write_cyc = cyc; end
    if (fft_start) begin n_start++; start_cyc = cyc; mv_seen = 1'b0; end
    if (m_valid && !mv_seen) begin mv_seen = 1'b1; mv_cyc = cyc; end
  end

  logic [127:0] exp_re, exp_im, got_re, got_im;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] re, input logic [15:0] im, input bit last);
    bit ok;
    int t;
    s_valid = 1'b1; s_real = re; s_imag = im; s_last = last;
    ok = 1'b0; t = 0;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = s_ready;
      step();
      t++;
    end
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [15:0] r0, input logic [15:0] rs, input logic [15:0] i0, input logic [15:0] is);
    logic [127:0] xr, xi;
    for (int n = 0; n < 8; n++) begin
      xr[n*16 +: 16] = r0 + 16'(n) * rs;
      xi[n*16 +: 16] = i0 + 16'(n) * is;
      push(xr[n*16 +: 16], xi[n*16 +: 16], n == 7);
    end
    s_valid = 1'b0; s_last = 1'b0;
    exp_re = scale_vec(dft_part(xr, xi, 1'b0));
    exp_im = scale_vec(dft_part(xr, xi, 1'b1));
  endtask

  task automatic drain(input bit bp);
    int nxt, stalls, t;
    bit tog, have_snap;
    logic [35:0] snap;
    nxt = 0; stalls = 0; t = 0; tog = 1'b1; have_snap = 1'b0; snap = '0;
    while (nxt < 8 && t < 200) begin
      if (!bp || nxt < 2) m_ready = 1'b1;
      else if (nxt == 2 && stalls < 3) m_ready = 1'b0;
      else begin m_ready = tog; tog = ~tog; end
      @(negedge clk);
      if (m_valid) begin
        if (have_snap) check("stall_hold", {m_real, m_imag, m_index, m_last}, snap);
        check("s_ready_in_drain", s_ready, 0);
        if (m_ready) begin
          check("m_index", m_index, nxt);
          check("m_real", m_real, exp_re[nxt*16 +: 16]);
          check("m_imag", m_imag, exp_im[nxt*16 +: 16]);
          check("m_last", m_last, nxt == 7);
          check("busy_drain", busy, 1);
          got_re[nxt*16 +: 16] = m_real;
          got_im[nxt*16 +: 16] = m_imag;
          nxt++;
          have_snap = 1'b0;
        end else begin
          snap = {m_real, m_imag, m_index, m_last};
          have_snap = 1'b1;
          if (nxt == 2) stalls++;
        end
      end
      step();
      t++;
    end
    m_ready = 1'b0;
    if (nxt < 8) check("drain_timeout", nxt, 8);
    check("s_ready_after_last", s_ready, 1);
    check("m_valid_after_last", m_valid, 0);
  endtask

  initial begin
    int w0, s0, prev_w;
    bit any_mv;
    rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; m_ready = 1'b0;
    got_re = '0; got_im = '0; exp_re = '0; exp_im = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_fft_write", fft_write, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_m_index", m_index, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_fft_in_real", fft_in_real, 0);
    step();

    // Ramp frame
    w0 = n_write; s0 = n_start;
    send_frame(16'h0000, 16'h0100, 16'h0000, 16'h0000);
    drain(1'b0);
    check("ramp_write_pulses", n_write - w0, 1);
    check("ramp_start_pulses", n_start - s0, 1);
    check("write_to_start", start_cyc - write_cyc, 1);
    check("start_to_valid", mv_cyc - start_cyc, LAT + 1);
`ifdef FFT_SEQ_SCALE_EN
    check("ramp_x0_re", got_re[15:0], 16'h0380);
    check("ramp_x4_re", got_re[79:64], 16'hFF80);
`else
    check("ramp_x0_re", got_re[15:0], 16'h1C00);
    check("ramp_x4_re", got_re[79:64], 16'hFC00);
`endif
    check("ramp_x0_im", got_im[15:0], 16'h0000);
    check("ramp_count", frame_count, 1);

    // Backpressure
    send_frame(16'h0040, 16'h0011, 16'hFFF0, 16'h0003);
    drain(1'b1);
    check("bp_count", frame_count, 2);

    // Early s_last on the 5th sample
    w0 = n_write;
    for (int n = 0; n < 4; n++) push(16'h7000 + 16'(n), 16'h0000, 1'b0);
    push(16'h7004, 16'h0000, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    step(); step(); step();
    check("early_frame_err", frame_err, 1);
    check("early_no_write", n_write - w0, 0);
    check("early_s_ready", s_ready, 1);
    check("early_busy", busy, 0);
    send_frame(16'h0200, 16'hFF80, 16'h0010, 16'h0020);
    drain(1'b0);
    check("early_next_count", frame_count, 3);
    check("early_err_sticky", frame_err, 1);

    // Reset during WAIT
    s0 = n_start;
    send_frame(16'h1000, 16'h0101, 16'h0000, 16'h0040);
    step(); step(); step();
    check("rst_mid_started", n_start - s0, 1);
    w0 = n_write;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_s_ready", s_ready, 1);
    check("rst_mid_count", frame_count, 0);
    check("rst_mid_err_clear", frame_err, 0);
    any_mv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk);
      if (m_valid) any_mv = 1'b1;
    end
    step();
    check("rst_mid_no_m_valid", any_mv, 0);
    check("rst_mid_no_write", n_write - w0, 0);
    send_frame(16'h0123, 16'h0042, 16'hFF00, 16'h0031);
    drain(1'b0);
    check("rst_mid_new_count", frame_count, 1);

    // Back-to-back frames with counter wrap
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("b2b_count_rst", frame_count, 0);
    prev_w = 0;
    for (int f = 0; f < 5; f++) begin
      send_frame(16'(f) * 16'h0100, 16'h0030, 16'(f) * 16'h0005, 16'hFFFE);
      drain(1'b0);
      if (f > 0) check("b2b_period", write_cyc - prev_w, 18 + LAT);
      prev_w = write_cyc;
      if (f == 2) check("b2b_count3", frame_count, 3);
    end
    check("b2b_wrap_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Front-end controller for the 8-point FFT core. It collects a serial stream of complex samples into an 8-entry frame buffer and presents them in parallel to the core. It pulses the core's write and start controls, waits the core's fixed latency, then captures the 8 results. It streams the results out serially with a valid/ready handshake.

Parameters:
DATA_W, 16, width of each real/imag component (two's complement)
FFT_LATENCY, 4, cycles from the fft_start cycle until fft_out_* are valid; legal range 1..255
CNT_W, 16, width of frame_count

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  sequencer can accept a sample
s_real  in  DATA_W  input sample real part
s_imag  in  DATA_W  input sample imaginary part
s_last  in  1  producer marks the final sample of a frame
fft_write  out  1  one-cycle load strobe to the core
fft_start  out  1  one-cycle start strobe to the core
fft_in_real  out  8*DATA_W  sample k real at bits [k*DATA_W +: DATA_W]
fft_in_imag  out  8*DATA_W  sample k imaginary, same packing
fft_out_real  in  8*DATA_W  core result X[k] real, same packing
fft_out_imag  in  8*DATA_W  core result X[k] imaginary, same packing
m_valid  out  1  output result valid
m_ready  in  1  consumer accepts the result
m_real  out  DATA_W  X[m_index] real
m_imag  out  DATA_W  X[m_index] imaginary
m_index  out  3  bin index 0..7
m_last  out  1  high with index 7
busy  out  1  high in every state except FILL
frame_err  out  1  sticky; set on an early s_last
frame_count  out  CNT_W  completed frames; wraps

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is FILL.
  - All counters are 0, the input buffer is 0 and the result buffer is 0.
  - s_ready = 1 on the first cycle after reset.
  - fft_write, fft_start, m_valid, m_last, busy and frame_err are 0.
  - m_index = 0 and frame_count = 0.
  - fft_in_* = 0.
- Reset asserted in any state aborts the frame: buffered data is discarded and no strobes are issued afterwards.
- FILL:
  - s_ready = 1.
  - On s_valid & s_ready, the sample is written to buffer slot wr_idx and wr_idx increments.
  - When slot 7 is accepted, the next state is LOAD and wr_idx returns to 0.
  - s_last on slot 7, or no s_last at slot 7, completes the frame normally.
  - s_last with wr_idx < 7: set frame_err, discard the partial frame, set wr_idx = 0 and stay in FILL. The next accepted sample goes to slot 0.
- LOAD (1 cycle): fft_write = 1, s_ready = 0. fft_in_* is driven from the buffer and is stable from LOAD until the next FILL.
- START (1 cycle): fft_start = 1. The latency counter is cleared.
- WAIT:
  - The latency counter increments each cycle.
  - Let S be the START cycle. On the clock edge ending cycle S+FFT_LATENCY, fft_out_* is sampled into the result buffer. The next state is DRAIN.
- DRAIN:
  - m_valid = 1 from cycle S+FFT_LATENCY+1.
  - m_real and m_imag are driven from the result buffer at rd_idx; m_index = rd_idx; m_last = (rd_idx == 7).
  - rd_idx advances only on m_valid & m_ready. With m_ready low, all m_* outputs hold unchanged.
  - The handshake with m_last: frame_count increments (wrapping), rd_idx = 0, next state is FILL, and s_ready = 1 in the next cycle.
- Throughput: no overlap. The minimum frame period is 8 + 2 + FFT_LATENCY + 8 cycles.
- Simultaneous events:
  - s_valid arriving while s_ready = 0 is ignored; the producer holds the sample.
  - Reset takes priority over every handshake.
  - frame_err clears only on rst.

Optional Feature:
- Macro: FFT_SEQ_SCALE_EN.
- Defined: each captured result component is scaled by 1/8 with rounding before storage.
  - Sign-extend the component to DATA_W+1 bits, add 4, arithmetic-shift right by 3, truncate to DATA_W.
  - This cannot overflow.
- Undefined: results are stored and output unmodified.
- Latency is identical in both builds.

Test Plan:
- Ramp frame, with a behavioural core model and FFT_LATENCY=4:
  - Stimulus: s_real = 0x0000, 0x0100, ..., 0x0700; s_imag = 0; s_valid held high.
  - Required: exactly one fft_write pulse, followed next cycle by exactly one fft_start pulse.
  - Required: first m_valid 5 cycles after fft_start.
  - Required: index 0 → m_real 0x1C00, m_imag 0; index 4 → m_real 0xFC00; m_last only on index 7; frame_count = 1.
- Backpressure:
  - Stimulus: m_ready low for 3 cycles at index 2, and toggled every cycle afterwards.
  - Required: m_* is stable while stalled; indices 0..7 are each delivered exactly once, in order; s_ready stays 0 until after the m_last handshake.
- Early s_last:
  - Stimulus: s_last on the 5th sample.
  - Required: frame_err = 1; no fft_write pulse. The next 8 samples form a normal frame and produce correct results.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during WAIT.
  - Required: no capture; m_valid stays 0; frame_count = 0; s_ready = 1 on the cycle after rst deasserts. A new frame then processes normally.
- Back-to-back frames:
  - Stimulus: 3 frames with m_ready held high.
  - Required: frame_count = 3; each frame's period is 18 + FFT_LATENCY cycles; wrap checked with CNT_W = 2 over 5 frames (frame_count = 1).
- FFT_SEQ_SCALE_EN build:
  - Stimulus: the ramp frame.
  - Required: index 0 → m_real 0x0380; index 4 → m_real 0xFF80.
